// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU/MDU (opcodes, func3/func7, FSM states, M-op kinds).
package alu_pkg;

  localparam logic [6:0] OP_R         = 7'b0110011;
  localparam logic [6:0] OP_IMM       = 7'b0010011;
  localparam logic [6:0] FUNC7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Values follow the RV M-extension func3 encoding so func3 casts directly.
  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } mop_e;

  function automatic logic mop_is_div(input mop_e m);
    return m inside {M_DIV, M_DIVU, M_REM, M_REMU};
  endfunction

endpackage

// File: rtl/alu_mdu_seq_core.sv
// mdu_shift_core: one-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
// hi/lo hold {product high, product low} or {remainder, quotient} after XLEN steps.
module mdu_shift_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  acc_q, acc_d, mq_q, mq_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [XLEN:0]    sum, rem_sh, diff;

  always_comb begin
    acc_d  = acc_q;
    mq_d   = mq_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {acc_q, mq_q[XLEN-1]};
    diff   = rem_sh - {1'b0, b_q};
    done   = step && (cnt_q == CNT_W'(XLEN - 1));
    if (start) begin
      acc_d = '0;
      mq_d  = a_mag;
      b_d   = b_mag;
      cnt_d = '0;
      div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        // Partial remainder stays below the divisor, so XLEN bits hold it after restore.
        acc_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        mq_d  = {mq_q[XLEN-2:0], ~diff[XLEN]};
      end else begin
        acc_d = sum[XLEN:1];
        mq_d  = {sum[0], mq_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mq_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign hi = acc_q;
  assign lo = mq_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked execute-stage ALU, single-cycle base ops plus iterative RV32M/RV64M mul/div.
// Define ALU_FAST_MUL_EN for a combinational multiplier (MUL/MULH* go IDLE->FIX->DONE).
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            negative_flag,
  output logic            overflow_flag,
  output logic            busy
);
  localparam int unsigned SHAMT_W = $clog2(XLEN);

  state_e          state_q, state_d;
  mop_e            mop_q, mop_d, mop_in;
  logic            neg1_q, neg1_d, neg2_q, neg2_d, dz_q, dz_d;
  logic [XLEN-1:0] op1_q, op1_d, result_q, result_d;
  logic [3:0]      flags_q, flags_d;  // {carry, zero, negative, overflow}

  logic              is_m, is_sub, accept, neg1_in, neg2_in, core_start, core_done;
  logic [XLEN-1:0]   a_mag, b_mag, addend, base_res, sra_res, core_hi, core_lo, q_s, r_s, fix_res;
  logic [XLEN:0]     sum_w;
  logic [SHAMT_W-1:0] shamt;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [3:0]        add_flags;
`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_q, prod_d;
`endif

  always_comb begin
    is_m    = (opcode == OP_R) && (func7 == FUNC7_MULDIV);
    is_sub  = (opcode == OP_R) && (func7 == FUNC7_SUB);
    mop_in  = mop_e'(func3);
    accept  = in_valid && (state_q == IDLE) && !flush;
    neg1_in = (mop_in inside {M_MULH, M_MULHSU, M_DIV, M_REM}) && op1[XLEN-1];
    neg2_in = (mop_in inside {M_MULH, M_DIV, M_REM}) && op2[XLEN-1];
    a_mag   = neg1_in ? -op1 : op1;
    b_mag   = neg2_in ? -op2 : op2;
    shamt   = op2[SHAMT_W-1:0];
    addend  = is_sub ? ~op2 : op2;
    sum_w   = {1'b0, op1} + {1'b0, addend} + {{XLEN{1'b0}}, is_sub};
    sra_res = $unsigned($signed(op1) >>> shamt);
    add_flags = {sum_w[XLEN], sum_w[XLEN-1:0] == '0, sum_w[XLEN-1],
                 (op1[XLEN-1] == addend[XLEN-1]) && (sum_w[XLEN-1] != op1[XLEN-1])};
    base_res = op1 & op2;
    case (func3)
      F3_ADD:  base_res = sum_w[XLEN-1:0];
      F3_SLL:  base_res = op1 << shamt;
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, op1 < op2};
      F3_XOR:  base_res = op1 ^ op2;
      F3_SR:   base_res = func7[5] ? sra_res : (op1 >> shamt);
      F3_OR:   base_res = op1 | op2;
      default: base_res = op1 & op2;
    endcase
  end

  // Sign correction happens once, on the full 2*XLEN product / quotient / remainder.
  always_comb begin
`ifdef ALU_FAST_MUL_EN
    prod = mop_is_div(mop_q) ? {core_hi, core_lo} : prod_q;
`else
    prod = {core_hi, core_lo};
`endif
    prod_s = (neg1_q ^ neg2_q) ? -prod : prod;
    q_s    = (neg1_q ^ neg2_q) ? -core_lo : core_lo;
    r_s    = neg1_q ? -core_hi : core_hi;
    case (mop_q)
      M_MUL:                     fix_res = prod_s[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             fix_res = dz_q ? '1 : q_s;
      default:                   fix_res = dz_q ? op1_q : r_s;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mop_d      = mop_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    dz_d       = dz_q;
    op1_d      = op1_q;
    result_d   = result_q;
    flags_d    = flags_q;
    core_start = 1'b0;
`ifdef ALU_FAST_MUL_EN
    prod_d     = prod_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mop_d  = mop_in;
          neg1_d = neg1_in;
          neg2_d = neg2_in;
          dz_d   = (op2 == '0);
          op1_d  = op1;
          if (!is_m) begin
            state_d  = DONE;
            result_d = base_res;
            flags_d  = (func3 == F3_ADD) ? add_flags : '0;
          end
`ifdef ALU_FAST_MUL_EN
          else if (!mop_is_div(mop_in)) begin
            prod_d  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
            state_d = FIX;
          end
`endif
          else begin
            core_start = 1'b1;
            state_d    = CALC;
          end
        end
        CALC: if (core_done) state_d = FIX;
        FIX: begin
          result_d = fix_res;
          flags_d  = '0;
          state_d  = DONE;
        end
        default: if (out_ready) state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mop_q    <= M_MUL;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      dz_q     <= 1'b0;
      op1_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_FAST_MUL_EN
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mop_q    <= mop_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      dz_q     <= dz_d;
      op1_q    <= op1_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef ALU_FAST_MUL_EN
      prod_q   <= prod_d;
`endif
    end
  end

  mdu_shift_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .step   (state_q == CALC),
    .is_div (mop_is_div(mop_in)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q == CALC) || (state_q == FIX);
  assign result        = result_q;
  assign carry_flag    = flags_q[3];
  assign zero_flag     = flags_q[2];
  assign negative_flag = flags_q[1];
  assign overflow_flag = flags_q[0];

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: scoreboard bench for alu_mdu_seq (XLEN=32) with a behavioural RV32IM reference model.
module tb_alu_mdu_seq;
  localparam int unsigned XLEN = 32;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, busy, cf, zf, nf, vf;
  logic [31:0] op1 = '0, op2 = '0, result;
  logic [6:0]  opcode = '0, func7 = '0;
  logic [2:0]  func3 = '0;
  int          total = 0, bad = 0;

  typedef struct { logic [31:0] r; logic [3:0] f; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .opcode(opcode), .func3(func3), .func7(func7),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_flag(cf), .zero_flag(zf), .negative_flag(nf), .overflow_flag(vf), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32IM semantics in plain arithmetic; flags {carry, zero, negative, overflow}.
  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] fl, output int lat);
    longint sa, sb, p, s;
    logic [63:0] up;
    logic c, v, fast;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    fast = 1'b0;
`ifdef ALU_FAST_MUL_EN
    fast = 1'b1;
`endif
    fl = '0; r = '0; lat = 1;
    if (opc == OPR && f7 == 7'b0000001) begin
      lat = (fast && f3 < 3'd4) ? 2 : XLEN + 2;
      case (f3)
        3'd0: r = a * b;
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
        3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
        3'd4: if (b == 0) r = '1; else if (a == 32'h80000000 && b == '1) r = a; else begin p = sa / sb; r = p[31:0]; end
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) r = a; else if (a == 32'h80000000 && b == '1) r = '0; else begin p = sa % sb; r = p[31:0]; end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (f3)
        3'd0: begin
          if (opc == OPR && f7 == 7'b0100000) begin
            r = a - b; c = (a >= b); s = sa - sb;
          end else begin
            r = a + b; up = {32'h0, a} + {32'h0, b}; c = up[32]; s = sa + sb;
          end
          v = (s > SMAX) || (s < SMIN);
          fl = {c, r == 0, r[31], v};
        end
        3'd1: r = a << b[4:0];
        3'd2: r = {31'b0, sa < sb};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: if (f7[5]) begin s = sa >>> b[4:0]; r = s[31:0]; end else r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  // Scoreboard monitor: every completed handshake is checked against the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", out_valid, 1'b0);
      else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.r);
        chk("flags", {cf, zf, nf, vf}, mon_e.f);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("idle_timeout", in_ready, 1'b1);
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int lat, n;
    logic [31:0] held;
    wait_idle();
    model(opc, f3, f7, a, b, e.r, e.f, lat);
    opcode = opc; func3 = f3; func7 = f7; op1 = a; op2 = b;
    in_valid = 1'b1; out_ready = (hold == 0);
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n + 1), 64'(lat));
    if (hold > 0) begin
      held = result;
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_stable", result, held);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", out_valid, 1'b0);
      chk("bp_idle", in_ready, 1'b1);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    int vcount;
    #1 rst_n = 1'b0;
    #5;
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {cf, zf, nf, vf}, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OPR, 3'd0, 7'h00, 32'h7FFFFFFF, 32'h1, 0);
    issue(OPR, 3'd0, 7'h20, 32'd5, 32'd5, 0);
    issue(OPI, 3'd0, 7'h00, 32'hFFFFFFFF, 32'h1, 0);
    issue(OPR, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 0);
    issue(OPR, 3'd3, 7'h01, 32'hFFFFFFFF, 32'd2, 0);
    issue(OPR, 3'd0, 7'h01, -32'sd3, 32'd7, 0);
    issue(OPR, 3'd2, 7'h01, -32'sd5, 32'hFFFFFFFF, 0);
    issue(OPR, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0);
    issue(OPR, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0);
    issue(OPR, 3'd5, 7'h01, 32'd7, 32'd0, 0);
    issue(OPR, 3'd7, 7'h01, 32'd7, 32'd0, 0);
    issue(OPR, 3'd4, 7'h01, -32'sd7, 32'd0, 0);
    issue(OPR, 3'd6, 7'h01, -32'sd7, 32'd0, 0);
    issue(OPR, 3'd4, 7'h01, -32'sd7, 32'd2, 0);
    issue(OPR, 3'd6, 7'h01, -32'sd7, 32'd2, 0);
    issue(OPR, 3'd5, 7'h20, 32'h80000010, 32'd4, 0);
    issue(OPI, 3'd5, 7'h00, 32'h80000010, 32'd4, 0);
    issue(OPR, 3'd2, 7'h00, 32'hFFFFFFFE, 32'd1, 0);
    issue(OPR, 3'd5, 7'h01, 32'd1000, 32'd9, 5);
    issue(OPR, 3'd0, 7'h20, 32'd3, 32'd9, 5);

    // Flush at CALC iteration 10; result must keep its last value.
    wait_idle();
    held = result;
    opcode = OPR; func3 = 3'd4; func7 = 7'h01; op1 = 32'd1000; op2 = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("calc_busy", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_result_kept", result, held);
    vcount = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) vcount++; end
    chk("flush_no_valid", 64'(vcount), 64'd0);
    issue(OPR, 3'd5, 7'h01, 32'd100, 32'd7, 0);

    // flush together with in_valid in IDLE: nothing accepted.
    wait_idle();
    opcode = OPR; func3 = 3'd0; func7 = 7'h00; op1 = 32'd1; op2 = 32'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_valid", out_valid, 1'b0);
    chk("flush_idle_ready", in_ready, 1'b1);

    // Asynchronous reset mid-CALC, away from any clock edge.
    opcode = OPR; func3 = 3'd3; func7 = 7'h01; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_flags", {cf, zf, nf, vf}, 4'h0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [6:0] ropc, rf7;
      logic [2:0] rf3;
      ropc = ($urandom_range(0, 3) == 0) ? OPI : OPR;
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        default: rf7 = 7'h01;
      endcase
      issue(ropc, rf3, rf7, pick(), pick(), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
